delay_timer: RTL and testbench

DELAY_TIMER -- requirements
Module: delay_timer

---
 rtl/timer_pkg.sv | 14 +
 rtl/delay_timer.sv | 93 +++++++++
 tb/tb_delay_timer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types for the delay timer.
// State encoding and counting-mode selectors.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;

endpackage

// File: rtl/delay_timer.sv
// Armable up-counter with a sticky threshold flag and a
// terminal action that either saturates or wraps.
module delay_timer
  import timer_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int THRESHOLD = 3,
  parameter int MAX_COUNT = 7,
  parameter int MODE      = 0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic             en,
  input  logic             sclr,
  output logic [WIDTH-1:0] count,
  output logic             delay,
  output logic             done,
  output logic             wrap,
  output logic             busy
);

  if (!(THRESHOLD >= 0 &&
        THRESHOLD <= MAX_COUNT &&
        MAX_COUNT <= (2**WIDTH) - 1 &&
        (MODE == MODE_SAT || MODE == MODE_WRAP)))
  begin : g_bad_params
    $error("delay_timer: illegal parameters");
  end

  localparam logic [WIDTH-1:0] THR  = WIDTH'(THRESHOLD);
  localparam logic [WIDTH-1:0] MAXC = WIDTH'(MAX_COUNT);

  state_e           state;
  state_e           state_n;
  logic [WIDTH-1:0] count_n;
  logic             delay_n;
  logic             done_n;
  logic             wrap_n;

  // sclr beats start beats advance; wrap is a pulse
  always_comb begin
    state_n = state;
    count_n = count;
    delay_n = delay;
    done_n  = done;
    wrap_n  = 1'b0;
    if (sclr) begin
      state_n = IDLE;
      count_n = '0;
      delay_n = 1'b0;
      done_n  = 1'b0;
    end else if (start) begin
      state_n = RUN;
      count_n = '0;
      delay_n = 1'b0;
      done_n  = 1'b0;
    end else if (state == RUN && en) begin
      if (count == THR)
        delay_n = 1'b1;
      if (count == MAXC) begin
        if (MODE == MODE_WRAP) begin
          count_n = '0;
          wrap_n  = 1'b1;
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end else begin
        count_n = count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      count <= '0;
      delay <= 1'b0;
      done  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      delay <= delay_n;
      done  <= done_n;
      wrap  <= wrap_n;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_delay_timer.sv
// Bench for delay_timer: three configurations driven in lockstep
// and compared against an arithmetic reference model.
module tb_delay_timer;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  logic start = 1'b0;
  logic en = 1'b0;
  logic sclr = 1'b0;

  logic [2:0] c0, c1;
  logic [3:0] c2;
  logic d0, d1, d2, n0, n1, n2;
  logic w0, w1, w2, b0, b1, b2;

  int tests_run = 0;
  int failed = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  delay_timer u_sat (
    .clk(clk), .clear_n(clear_n), .start(start),
    .en(en), .sclr(sclr), .count(c0), .delay(d0),
    .done(n0), .wrap(w0), .busy(b0)
  );

  delay_timer #(.MODE(1)) u_wrap (
    .clk(clk), .clear_n(clear_n), .start(start),
    .en(en), .sclr(sclr), .count(c1), .delay(d1),
    .done(n1), .wrap(w1), .busy(b1)
  );

  delay_timer #(
    .WIDTH(4), .THRESHOLD(9), .MAX_COUNT(9), .MODE(0)
  ) u_eq (
    .clk(clk), .clear_n(clear_n), .start(start),
    .en(en), .sclr(sclr), .count(c2), .delay(d2),
    .done(n2), .wrap(w2), .busy(b2)
  );

  logic [7:0] act [3];
  assign act[0] = {b0, n0, w0, d0, 1'b0, c0};
  assign act[1] = {b1, n1, w1, d1, 1'b0, c1};
  assign act[2] = {b2, n2, w2, d2, c2};

  localparam int P_THR  [3] = '{3, 3, 9};
  localparam int P_MAX  [3] = '{7, 7, 9};
  localparam int P_MODE [3] = '{0, 1, 0};

  int m_cnt [3];
  bit m_dly [3];
  bit m_done[3];
  bit m_wrap[3];
  bit m_run [3];

  function automatic logic [7:0] exp_of(int k);
    return {m_run[k], m_done[k], m_wrap[k], m_dly[k], 4'(m_cnt[k])};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_dly[k] = 0; m_done[k] = 0;
      m_wrap[k] = 0; m_run[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      m_wrap[k] = 0;
      if (sclr) begin
        m_cnt[k] = 0; m_dly[k] = 0; m_done[k] = 0; m_run[k] = 0;
      end else if (start) begin
        m_cnt[k] = 0; m_dly[k] = 0; m_done[k] = 0; m_run[k] = 1;
      end else if (m_run[k] && en) begin
        if (m_cnt[k] == P_THR[k]) m_dly[k] = 1;
        if (m_cnt[k] < P_MAX[k]) m_cnt[k] = m_cnt[k] + 1;
        else if (P_MODE[k] == 1) begin
          m_cnt[k] = 0; m_wrap[k] = 1;
        end else begin
          m_run[k] = 0; m_done[k] = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (act[k] !== 8'h00) begin
        failed++;
        $display("FAIL reset dut%0d got %b exp %b", k, act[k], 8'h00);
      end
    end
    @(negedge clk);
    clear_n = 1'b1;
    en = 1'b1;
    repeat (2) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (act[k] !== exp_of(k)) begin
          failed++;
          $display("FAIL reset_idle dut%0d got %b exp %b",
                   k, act[k], exp_of(k));
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    start = 1'b1;
    tick();
    start = 1'b0;
    en = 1'b1;
    repeat (12) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (act[k] !== exp_of(k)) begin
          failed++;
          $display("FAIL saturate dut%0d cyc%0d got %b exp %b",
                   k, cyc, act[k], exp_of(k));
        end
      end
    end
    en = 1'b0;
    tests_run++;
    if ({b0, n0, d0, c0} !== {1'b0, 1'b1, 1'b1, 3'd7}) begin
      failed++;
      $display("FAIL sat_final got %b exp %b",
               {b0, n0, d0, c0}, 6'b011111);
    end
    tests_run++;
    if ({b2, n2, d2, c2} !== {1'b0, 1'b1, 1'b1, 4'd9}) begin
      failed++;
      $display("FAIL eq_final got %b exp %b",
               {b2, n2, d2, c2}, 7'b0111001);
    end
    tests_run++;
    if ({b1, n1, d1, c1} !== {1'b1, 1'b0, 1'b1, 3'd4}) begin
      failed++;
      $display("FAIL wrap_after12 got %b exp %b",
               {b1, n1, d1, c1}, 6'b101100);
    end
  endtask

  task automatic test_wrap();
    int pulses;
    pulses = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    en = 1'b1;
    repeat (10) begin
      tick();
      if (w1) pulses++;
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (act[k] !== exp_of(k)) begin
          failed++;
          $display("FAIL wrap dut%0d cyc%0d got %b exp %b",
                   k, cyc, act[k], exp_of(k));
        end
      end
    end
    en = 1'b0;
    tests_run++;
    if (pulses !== 1 || c1 !== 3'd2 || d1 !== 1'b1) begin
      failed++;
      $display("FAIL wrap_pulse got p=%0d c=%0d d=%b exp p=1 c=2 d=1",
               pulses, c1, d1);
    end
  endtask

  task automatic test_en_toggle();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      en = (i % 2 == 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (act[k] !== exp_of(k)) begin
          failed++;
          $display("FAIL en_toggle dut%0d cyc%0d got %b exp %b",
                   k, cyc, act[k], exp_of(k));
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_restart();
    start = 1'b1;
    tick();
    start = 1'b0;
    en = 1'b1;
    repeat (5) tick();
    en = 1'b0;
    tests_run++;
    if (c0 !== 3'd5 || d0 !== 1'b1) begin
      failed++;
      $display("FAIL restart_pre got c=%0d d=%b exp c=5 d=1", c0, d0);
    end
    start = 1'b1;
    tick();
    tests_run++;
    if ({b0, d0, c0} !== {1'b1, 1'b0, 3'd0}) begin
      failed++;
      $display("FAIL restart got %b exp %b", {b0, d0, c0}, 5'b10000);
    end
    sclr = 1'b1;
    tick();
    start = 1'b0;
    sclr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (act[k] !== exp_of(k) || act[k] !== 8'h00) begin
        failed++;
        $display("FAIL start_sclr dut%0d got %b exp %b",
                 k, act[k], 8'h00);
      end
    end
  endtask

  task automatic test_async_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    en = 1'b1;
    repeat (6) tick();
    en = 1'b0;
    tests_run++;
    if (c0 !== 3'd6 || b0 !== 1'b1) begin
      failed++;
      $display("FAIL clr_pre got c=%0d b=%b exp c=6 b=1", c0, b0);
    end
    #2;
    clear_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (act[k] !== 8'h00) begin
        failed++;
        $display("FAIL async_clear dut%0d got %b exp %b",
                 k, act[k], 8'h00);
      end
    end
    #1;
    clear_n = 1'b1;
    en = 1'b1;
    repeat (4) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (act[k] !== exp_of(k) || act[k] !== 8'h00) begin
          failed++;
          $display("FAIL clr_idle dut%0d cyc%0d got %b exp %b",
                   k, cyc, act[k], 8'h00);
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      sclr  = ($urandom_range(15) == 0);
      start = ($urandom_range(9) == 0);
      en    = ($urandom_range(9) < 7);
      tick();
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (act[k] !== exp_of(k)) begin
          failed++;
          $display("FAIL random dut%0d cyc%0d got %b exp %b",
                   k, cyc, act[k], exp_of(k));
        end
      end
    end
    sclr = 1'b0;
    start = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_wrap();
    test_en_toggle();
    test_restart();
    test_async_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
